// File: rtl/serial_frame_deserializer.sv
// Purpose: receive start/data/parity/stop serial frames, sampled on bit_en_i strobes, into parallel words.
// Latency: word is visible on data_o/valid_o one clk_i cycle after the stop-bit sample.
// Backpressure: a word is held until valid_o & ready_i; a frame completing while a word is still pending is dropped and flagged as overrun.
module serial_frame_deserializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  serial_i,
    input  logic                  bit_en_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_err_o,
    output logic                  parity_err_o,
    output logic                  overrun_o,
    input  logic                  clear_err_i
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    perr_q, perr_d;
    logic                    ovr_q, ovr_d;

    logic done;
    logic set_ferr;
    logic set_perr;
    logic set_ovr;
    logic hs;
    logic deliver;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        done      = 1'b0;
        set_ferr  = 1'b0;
        set_perr  = 1'b0;

        if (bit_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!serial_i) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        par_bad_d = 1'b0;
                    end
                end
                S_DATA: begin
                    // LSB arrives first, so shifting right leaves it in bit 0 after the last bit.
                    shreg_d = {serial_i, shreg_q[DATA_WIDTH-1:1]};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (serial_i != ((^shreg_q) ^ PAR_ODD)) begin
                        par_bad_d = 1'b1;
                        set_perr  = 1'b1;
                    end
                    state_d = S_STOP;
                end
                S_STOP: begin
                    done     = 1'b1;
                    set_ferr = !serial_i;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        hs      = valid_q & ready_i;
        set_ovr = done & valid_q & ~hs;
        // A handshake in the completion cycle frees the output slot for the new word.
        deliver = done & serial_i & ~par_bad_q & (~valid_q | hs);

        data_d  = deliver ? shreg_q : data_q;
        if (deliver) begin
            valid_d = 1'b1;
        end else if (hs) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        ferr_d = set_ferr | (ferr_q & ~clear_err_i);
        perr_d = set_perr | (perr_q & ~clear_err_i);
        ovr_d  = set_ovr  | (ovr_q  & ~clear_err_i);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer (DATA_WIDTH=8, even parity): vector table plus corner sequences,
// delivered words checked against a queue of expected words.
module tb_serial_frame_deserializer;

    logic       clk_i;
    logic       reset_ni;
    logic       serial_i;
    logic       bit_en_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;
    logic       clear_err_i;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    serial_frame_deserializer #(
        .DATA_WIDTH(8),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .serial_i    (serial_i),
        .bit_en_i    (bit_en_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o   (overrun_o),
        .clear_err_i (clear_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] dat;
        bit         par_flip;
        bit         stop;
        int         per;
        bit         exp_dlv;
        bit         exp_ferr;
        bit         exp_perr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake happens at the next rising edge; ready_i/valid_o are stable here.
    always @(negedge clk_i) begin
        logic [7:0] w;
        if (reset_ni && valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got 0x%0h expected no word", data_o);
            end else begin
                w = exp_q.pop_front();
                if (data_o !== w) begin
                    failures++;
                    $display("FAIL sb_word: got 0x%0h expected 0x%0h", data_o, w);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int per);
        serial_i = b;
        bit_en_i = 1'b1;
        tick(1);
        bit_en_i = 1'b0;
        if (per > 1) tick(per - 1);
    endtask

    task automatic send_head(input logic [7:0] d, input bit flip, input int per);
        logic p;
        p = (^d) ^ flip;
        send_bit(1'b0, per);
        for (int i = 0; i < 8; i++) send_bit(d[i], per);
        send_bit(p, per);
    endtask

    // Stop bit uses a single-cycle strobe so the caller regains control right after completion.
    task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop, input int per);
        send_head(d, flip, per);
        send_bit(stop, 1);
        serial_i = 1'b1;
    endtask

    task automatic clear_flags(input string tag);
        clear_err_i = 1'b1;
        tick(1);
        clear_err_i = 1'b0;
        check({tag, "_ferr_clr"}, 32'(frame_err_o), 32'd0);
        check({tag, "_perr_clr"}, 32'(parity_err_o), 32'd0);
        check({tag, "_ovr_clr"}, 32'(overrun_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h02, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h7E, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1};

        reset_ni    = 1'b1;
        serial_i    = 1'b1;
        bit_en_i    = 1'b0;
        ready_i     = 1'b1;
        clear_err_i = 1'b0;
        #2 reset_ni = 1'b0;
        #1;
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_flags", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);
        tick(2);
        reset_ni = 1'b1;
        tick(2);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].exp_dlv) exp_q.push_back(vecs[i].dat);
            send_frame(vecs[i].dat, vecs[i].par_flip, vecs[i].stop, vecs[i].per);
            check($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vecs[i].exp_dlv));
            if (vecs[i].exp_dlv) check($sformatf("v%0d_data", i), 32'(data_o), 32'(vecs[i].dat));
            tick(2);
            check($sformatf("v%0d_valid_drop", i), 32'(valid_o), 32'd0);
            check($sformatf("v%0d_ferr", i), 32'(frame_err_o), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_perr", i), 32'(parity_err_o), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_ovr", i), 32'(overrun_o), 32'd0);
            clear_flags($sformatf("v%0d", i));
        end

        // Back-to-back frames with ready high.
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h42);
        send_frame(8'h81, 1'b0, 1'b1, 1);
        send_frame(8'h42, 1'b0, 1'b1, 1);
        check("b2b_data2", 32'(data_o), 32'h42);
        tick(3);
        check("b2b_valid_drop", 32'(valid_o), 32'd0);
        check("b2b_ovr", 32'(overrun_o), 32'd0);

        // Overrun: second frame completes while the first is still pending.
        ready_i = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1, 1);
        send_frame(8'h22, 1'b0, 1'b1, 1);
        check("ovr_data", 32'(data_o), 32'h11);
        check("ovr_valid", 32'(valid_o), 32'd1);
        check("ovr_flag", 32'(overrun_o), 32'd1);
        tick(3);
        check("ovr_hold_data", 32'(data_o), 32'h11);
        check("ovr_hold_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        tick(2);
        check("ovr_valid_drop", 32'(valid_o), 32'd0);
        check("ovr_data_keep", 32'(data_o), 32'h11);
        clear_flags("ovr");

        // Handshake of the pending word in the same cycle as the next completion.
        ready_i = 1'b0;
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b0, 1'b1, 1);
        exp_q.push_back(8'h44);
        send_head(8'h44, 1'b0, 1);
        ready_i = 1'b1;
        send_bit(1'b1, 1);
        check("same_valid", 32'(valid_o), 32'd1);
        check("same_data", 32'(data_o), 32'h44);
        check("same_ovr", 32'(overrun_o), 32'd0);
        tick(2);
        check("same_valid_drop", 32'(valid_o), 32'd0);

        // Set beats clear when both happen in the same cycle.
        clear_err_i = 1'b1;
        send_frame(8'h5F, 1'b0, 1'b0, 1);
        clear_err_i = 1'b0;
        check("setwin_ferr", 32'(frame_err_o), 32'd1);
        check("setwin_valid", 32'(valid_o), 32'd0);
        clear_flags("setwin");

        // Reset mid-frame with a pending word, then a clean frame.
        ready_i = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 1);
        check("mid_pending", 32'(valid_o), 32'd1);
        send_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1);
        serial_i = 1'b1;
        #2 reset_ni = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_o), 32'd0);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_flags", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);
        tick(2);
        reset_ni = 1'b1;
        tick(1);
        ready_i = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        check("post_rst_data", 32'(data_o), 32'h5A);
        check("post_rst_valid", 32'(valid_o), 32'd1);
        tick(3);
        check("post_rst_flags", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_deserializer.md
SERIAL_FRAME_DESERIALIZER -- requirements
Module: serial_frame_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (legal range 2..32).
REQ-002 SHALL have parameter PARITY_EN, default 1, 1 = one parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port serial_i  input  1  serial line, idle high.
REQ-007 SHALL have port bit_en_i  input  1  bit strobe; serial_i is sampled only on cycles where bit_en_i = 1.
REQ-008 SHALL have port data_o  output  DATA_WIDTH  received word.
REQ-009 SHALL have port valid_o  output  1  data_o holds an unconsumed word.
REQ-010 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o & ready_i.
REQ-011 SHALL have port frame_err_o  output  1  sticky: stop bit sampled as 0.
REQ-012 SHALL have port parity_err_o  output  1  sticky: parity mismatch.
REQ-013 SHALL have port overrun_o  output  1  sticky: a frame completed while valid_o = 1 and no handshake occurred in that cycle.
REQ-014 SHALL have port clear_err_i  input  1  synchronous clear of all three sticky flags.

Function
REQ-015 Frame format SHALL be: start bit (0), DATA_WIDTH data bits LSB first, parity bit if PARITY_EN, then stop bit (1).
REQ-016 FSM SHALL have states IDLE, DATA, PARITY, STOP; all transitions occur only on cycles with bit_en_i = 1.
REQ-017 IDLE -> DATA SHALL occur when serial_i = 0 is sampled; serial_i = 1 keeps IDLE.
REQ-018 DATA SHALL shift the sampled bit into a DATA_WIDTH shift register at the MSB, shifting right, with a bit counter; after the DATA_WIDTH-th bit, go to PARITY if PARITY_EN, else STOP.
REQ-019 PARITY SHALL compare the sampled bit to XOR(data) ^ PARITY_ODD and then go to STOP.
REQ-020 STOP SHALL sample the stop bit, complete the frame, and return to IDLE.
REQ-021 On frame completion, the word SHALL be delivered (data_o loaded, valid_o = 1 on the next cycle), which implies 1-cycle latency from the stop-bit sample.
REQ-022 A completed frame SHALL be delivered only when stop = 1, parity is ok or disabled, and no word is pending.
REQ-023 Stop = 0 SHALL set frame_err_o, and the word SHALL be discarded.
REQ-024 A parity mismatch SHALL set parity_err_o, and the word SHALL be discarded.
REQ-025 A completed frame while valid_o = 1 and ready_i = 0 SHALL set overrun_o, drop the new word, and leave data_o unchanged.
REQ-026 When frame completion and a handshake (valid_o & ready_i) occur in the same cycle, the new word SHALL be loaded, valid_o SHALL stay 1, and there SHALL be no overrun.
REQ-027 A handshake without completion SHALL clear valid_o on the next cycle; data_o SHALL hold its last value.
REQ-028 data_o and valid_o SHALL NOT change while valid_o = 1 and ready_i = 0, except through reset.
REQ-029 When clear_err_i and an error set occur in the same cycle, the set SHALL win.
REQ-030 The bit_en_i = 0 cycles SHALL freeze the FSM, the counter and the shift register.
REQ-031 Back-to-back frames (stop bit followed immediately by a start bit on the next strobe) SHALL be received without loss.

Reset
REQ-032 reset_ni = 0 SHALL immediately, without a clock, force: IDLE, bit counter 0, shift register 0, data_o = 0, valid_o = 0, and frame_err_o = parity_err_o = overrun_o = 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no output and no error flag; after deassertion, reception SHALL restart at the next start bit.
REQ-034 Reset deassertion SHALL take effect at the next rising clk_i edge; no frame is in progress after reset.

Verification
REQ-035 Scenario: DATA_WIDTH=8, even parity, bit_en_i=1 every cycle, send 0xA5 (parity 0) with ready_i=1 -> data_o=0xA5, valid_o high exactly 1 cycle, no flags.
REQ-036 Scenario: send 0x3C with parity bit 1 -> parity_err_o=1, valid_o stays 0; then pulse clear_err_i -> parity_err_o=0.
REQ-037 Scenario: send 0x01 with stop bit 0 -> frame_err_o=1, no word delivered; the next valid frame 0x02 -> delivered.
REQ-038 Scenario: ready_i=0, send 0x11 then 0x22 back-to-back -> data_o=0x11, overrun_o=1; raising ready_i -> 0x11 accepted, valid_o falls.
REQ-039 Scenario: bit_en_i=1 one cycle in four, send 0xFF -> data_o=0xFF, and the FSM holds state on non-strobe cycles.
REQ-040 Scenario: reset_ni pulsed low after 4 data bits -> outputs 0 during reset, no flags; the following full frame 0x5A -> received correctly.
